// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants, state type and frame-word helper for the
// Clause-22 MDIO frame engine.
package mdio_pkg;

   localparam logic [1:0] ST_C22 = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_WR  = 2'b01;

   localparam int unsigned CMD_BITS  = 14;
   localparam int unsigned TA_BITS   = 2;
   localparam int unsigned DATA_BITS = 16;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      CMD,
      TA,
      DATA,
      DONE
   } mdio_state_t;

   // Everything after the preamble, MSB first. On reads the TA/DATA slots
   // hold ones, so the released line idles high.
   function automatic logic [31:0] frame_word(input logic        rd,
                                              input logic [4:0]  phy,
                                              input logic [4:0]  regad,
                                              input logic [15:0] wd);
      return {ST_C22, (rd ? OP_RD : OP_WR), phy, regad,
              (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wd)};
   endfunction

endpackage

// File: rtl/mdc_strobe_gen.sv
// mdc_strobe_gen: MDC divider. Counts 0..MDC_DIV-1 and toggles mdc on the
// terminal count. rise_stb/fall_stb flag the cycle whose closing edge
// registers mdc 0->1 / 1->0. Deasserting en clears the count and forces
// mdc low.
// Ports: clk, rst (async, active-high), en, mdc, rise_stb, fall_stb.
module mdc_strobe_gen #(
   parameter int unsigned MDC_DIV = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic mdc,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int unsigned CW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          tc;

   assign tc       = (cnt == CW'(MDC_DIV - 1));
   assign rise_stb = en & tc & ~mdc;
   assign fall_stb = en & tc & mdc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (tc) begin
         cnt <= '0;
         mdc <= ~mdc;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mdio_frame_engine.sv
// mdio_frame_engine: Clause-22 MDIO initiator. Accepts one register access
// (req_i & ready_o), emits preamble/ST/OP/PHYAD/REGAD/TA/DATA on MDC/MDIO,
// samples read data on MDC rising edges and returns data plus a no-PHY flag.
// Ports: clk_i, rst_i (async, active-high), req_i/ready_o handshake,
//   rd_i, phy_addr_i, reg_addr_i, wr_data_i request fields, done_o pulse,
//   rd_data_o/rd_err_o read result, mdc_o/mdio_o/mdio_oe_o/mdio_i pad side.
// Build option: MDIO_PRE_SUPPRESS_EN adds pre_skip_i to drop the preamble.
module mdio_frame_engine
   import mdio_pkg::*;
#(
   parameter int unsigned MDC_DIV = 25,
   parameter int unsigned PRE_LEN = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        ready_o,
   input  logic        rd_i,
   input  logic [4:0]  phy_addr_i,
   input  logic [4:0]  reg_addr_i,
   input  logic [15:0] wr_data_i,
`ifdef MDIO_PRE_SUPPRESS_EN
   input  logic        pre_skip_i,
`endif
   output logic        done_o,
   output logic [15:0] rd_data_o,
   output logic        rd_err_o,
   output logic        mdc_o,
   output logic        mdio_o,
   output logic        mdio_oe_o,
   input  logic        mdio_i
);

   mdio_state_t state;
   logic [5:0]  bit_cnt;
   logic [31:0] tx_sr;
   logic [15:0] rx_sr;
   logic        rd_q;
   logic        err_q;
   logic        last_bit;
   logic        skip_req;
   logic        strobe_en;
   logic        rise_stb;
   logic        fall_stb;
   logic [31:0] req_word;

`ifdef MDIO_PRE_SUPPRESS_EN
   assign skip_req = pre_skip_i;
`else
   assign skip_req = 1'b0;
`endif

   assign req_word  = frame_word(rd_i, phy_addr_i, reg_addr_i, wr_data_i);
   assign strobe_en = (state != IDLE) && (state != DONE);

   mdc_strobe_gen #(
      .MDC_DIV (MDC_DIV)
   ) u_strobe (
      .clk      (clk_i),
      .rst      (rst_i),
      .en       (strobe_en),
      .mdc      (mdc_o),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   always_comb begin
      last_bit = 1'b0;
      case (state)
         PRE:     last_bit = (bit_cnt == 6'(PRE_LEN - 1));
         CMD:     last_bit = (bit_cnt == 6'(CMD_BITS - 1));
         TA:      last_bit = (bit_cnt == 6'(TA_BITS - 1));
         DATA:    last_bit = (bit_cnt == 6'(DATA_BITS - 1));
         default: last_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         rd_q      <= 1'b0;
         err_q     <= 1'b0;
         ready_o   <= 1'b1;
         done_o    <= 1'b0;
         rd_data_o <= '0;
         rd_err_o  <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_oe_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i && ready_o) begin
                  ready_o   <= 1'b0;
                  rd_q      <= rd_i;
                  bit_cnt   <= '0;
                  mdio_oe_o <= 1'b1;
                  if (skip_req) begin
                     // First bit is presented right away, so the word enters
                     // the shifter already advanced by one.
                     state  <= CMD;
                     mdio_o <= req_word[31];
                     tx_sr  <= {req_word[30:0], 1'b0};
                  end else begin
                     state  <= PRE;
                     mdio_o <= 1'b1;
                     tx_sr  <= req_word;
                  end
               end
            end
            PRE, CMD, TA, DATA: begin
               if (rise_stb) begin
                  if (state == TA && last_bit) err_q <= mdio_i;
                  if (state == DATA) rx_sr <= {rx_sr[14:0], mdio_i};
               end
               if (fall_stb) begin
                  bit_cnt <= last_bit ? '0 : bit_cnt + 6'd1;
                  if (state == DATA && last_bit) begin
                     state     <= DONE;
                     mdio_o    <= 1'b1;
                     mdio_oe_o <= 1'b0;
                  end else begin
                     // Preamble bits stay at the idle 1; all later bits come
                     // from the shifter.
                     if (state != PRE || last_bit) begin
                        mdio_o <= tx_sr[31];
                        tx_sr  <= {tx_sr[30:0], 1'b0};
                     end
                     if (state == CMD && last_bit && rd_q) mdio_oe_o <= 1'b0;
                     if (last_bit) begin
                        case (state)
                           PRE:     state <= CMD;
                           CMD:     state <= TA;
                           default: state <= DATA;
                        endcase
                     end
                  end
               end
            end
            DONE: begin
               done_o    <= 1'b1;
               ready_o   <= 1'b1;
               mdio_o    <= 1'b1;
               mdio_oe_o <= 1'b0;
               if (rd_q) begin
                  rd_data_o <= rx_sr;
                  rd_err_o  <= err_q;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_frame_engine.sv
// tb_mdio_frame_engine: directed + randomized frames for mdio_frame_engine
// (MDC_DIV=2, PRE_LEN=32), checked against a bit-list model of the frame and
// a simple PHY that answers reads.
module tb_mdio_frame_engine;

   localparam int unsigned MDC_DIV = 2;
   localparam int unsigned PRE_LEN = 32;

   typedef struct {
      bit          rd;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [15:0] wd;
      bit          phy_on;
      logic [15:0] pd;
      bit          skip;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        ready;
   logic        rd;
   logic [4:0]  phy_addr;
   logic [4:0]  reg_addr;
   logic [15:0] wr_data;
   logic        done;
   logic [15:0] rd_data;
   logic        rd_err;
   logic        mdc;
   logic        mdio;
   logic        mdio_oe;
   logic        mdio_in;
`ifdef MDIO_PRE_SUPPRESS_EN
   logic        pre_skip;
`endif

   int vectors = 0;
   int miscompares = 0;
   int edge_no = 0;
   int last_done_edge = -100;
   logic [15:0] exp_rd_data = '0;
   logic        exp_rd_err = 1'b0;
   bit exp_bits[$];
   bit exp_oes[$];

   mdio_frame_engine #(
      .MDC_DIV (MDC_DIV),
      .PRE_LEN (PRE_LEN)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .ready_o    (ready),
      .rd_i       (rd),
      .phy_addr_i (phy_addr),
      .reg_addr_i (reg_addr),
      .wr_data_i  (wr_data),
`ifdef MDIO_PRE_SUPPRESS_EN
      .pre_skip_i (pre_skip),
`endif
      .done_o     (done),
      .rd_data_o  (rd_data),
      .rd_err_o   (rd_err),
      .mdc_o      (mdc),
      .mdio_o     (mdio),
      .mdio_oe_o  (mdio_oe),
      .mdio_i     (mdio_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_no++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic frame_t make_frame(input bit rd_v, input logic [4:0] p, input logic [4:0] r,
                                         input logic [15:0] w, input bit on, input logic [15:0] d,
                                         input bit sk);
      frame_t f;
      f.rd = rd_v; f.phy = p; f.regad = r; f.wd = w; f.phy_on = on; f.pd = d; f.skip = sk;
      return f;
   endfunction

   function automatic void push_field(input int unsigned val, input int unsigned w, input bit oe);
      for (int i = int'(w) - 1; i >= 0; i--) begin
         exp_bits.push_back(bit'((val >> i) & 1));
         exp_oes.push_back(oe);
      end
   endfunction

   // Expected pin value and output enable for every bit of the frame.
   function automatic void build_trace(input frame_t f);
      exp_bits.delete();
      exp_oes.delete();
      if (!f.skip)
         for (int i = 0; i < int'(PRE_LEN); i++) push_field(1, 1, 1'b1);
      push_field(1, 2, 1'b1);
      push_field(f.rd ? 2 : 1, 2, 1'b1);
      push_field(int'(f.phy), 5, 1'b1);
      push_field(int'(f.regad), 5, 1'b1);
      if (f.rd) begin
         push_field(0, 2, 1'b0);
         push_field(0, 16, 1'b0);
      end else begin
         push_field(2, 2, 1'b1);
         push_field(int'(f.wd), 16, 1'b1);
      end
   endfunction

   // Line level the PHY side presents during bit idx (pull-up when idle).
   function automatic logic phy_drive(input frame_t f, input int idx);
      int p;
      p = f.skip ? 0 : int'(PRE_LEN);
      if (!f.rd || !f.phy_on) return 1'b1;
      if (idx == p + 14) return 1'b1;
      if (idx == p + 15) return 1'b0;
      if (idx >= p + 16 && idx < p + 32) return f.pd[15 - (idx - p - 16)];
      return 1'b1;
   endfunction

   task automatic run_frame(input frame_t f, input bit hold, input frame_t nxt,
                            input bit chained, input int abort_bit);
      int n, waited, accept_edge, rises, run, budget;
      bit prev_mdc, prev_mdio, prev_oe, seen_done, aborted;
      build_trace(f);
      n = exp_bits.size();
      waited = 0;
      while (ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check("ready_before_accept", 32'(ready), 1);
      if (chained) check("chain_gap", edge_no + 1 - last_done_edge, 1);
      req = 1'b1; rd = f.rd; phy_addr = f.phy; reg_addr = f.regad; wr_data = f.wd;
`ifdef MDIO_PRE_SUPPRESS_EN
      pre_skip = f.skip;
`endif
      tick();
      accept_edge = edge_no;
      check("accept_ready_low", 32'(ready), 0);
      check("done_one_cycle", 32'(done), 0);
      check("first_bit_oe", 32'(mdio_oe), 1);
      if (hold) begin
         rd = nxt.rd; phy_addr = nxt.phy; reg_addr = nxt.regad; wr_data = nxt.wd;
`ifdef MDIO_PRE_SUPPRESS_EN
         pre_skip = nxt.skip;
`endif
      end else begin
         req = 1'b0;
         rd = 1'($urandom); phy_addr = 5'($urandom); reg_addr = 5'($urandom);
         wr_data = 16'($urandom);
      end
      rises = 0; run = 1; seen_done = 1'b0; aborted = 1'b0;
      prev_mdc = mdc; prev_mdio = mdio; prev_oe = mdio_oe;
      budget = 2 * int'(MDC_DIV) * n + 10;
      mdio_in = phy_drive(f, 0);
      for (int c = 0; c < budget && !seen_done; c++) begin
         tick();
         if (mdio !== prev_mdio || mdio_oe !== prev_oe)
            check("pin_change_on_fall", 32'({prev_mdc, mdc}), 2);
         if (mdc === prev_mdc) run++;
         else begin
            check("half_period", run, MDC_DIV);
            run = 1;
         end
         if (prev_mdc === 1'b0 && mdc === 1'b1) begin
            if (rises < n) begin
               check($sformatf("oe_bit%0d", rises), 32'(mdio_oe), 32'(exp_oes[rises]));
               if (exp_oes[rises])
                  check($sformatf("mdio_bit%0d", rises), 32'(mdio), 32'(exp_bits[rises]));
            end
            rises++;
         end
         if (abort_bit >= 0 && rises == abort_bit + 1 && mdc === 1'b1) begin
            rst = 1'b1;
            #1;
            check("abort_ready", 32'(ready), 1);
            check("abort_done", 32'(done), 0);
            check("abort_rd_data", 32'(rd_data), 0);
            check("abort_rd_err", 32'(rd_err), 0);
            check("abort_mdc", 32'(mdc), 0);
            check("abort_mdio", 32'(mdio), 1);
            check("abort_oe", 32'(mdio_oe), 0);
            exp_rd_data = '0;
            exp_rd_err = 1'b0;
            aborted = 1'b1;
            break;
         end
         mdio_in = phy_drive(f, rises);
         prev_mdc = mdc; prev_mdio = mdio; prev_oe = mdio_oe;
         if (done === 1'b1) seen_done = 1'b1;
      end
      mdio_in = 1'b1;
      if (aborted) begin
         req = 1'b0;
         tick();
         tick();
         rst = 1'b0;
         tick();
         return;
      end
      check("done_seen", 32'(seen_done), 1);
      if (seen_done) begin
         check("latency", edge_no - accept_edge, 2 * int'(MDC_DIV) * n + 1);
         check("bit_count", rises, n);
         if (f.rd) begin
            exp_rd_err = !f.phy_on;
            exp_rd_data = f.phy_on ? f.pd : 16'hFFFF;
         end
         check("rd_data", 32'(rd_data), 32'(exp_rd_data));
         check("rd_err", 32'(rd_err), 32'(exp_rd_err));
         check("done_ready", 32'(ready), 1);
         check("done_mdio", 32'(mdio), 1);
         check("done_oe", 32'(mdio_oe), 0);
         last_done_edge = edge_no;
      end
   endtask

   initial begin
      frame_t f, g;
      rst = 1'b1; req = 1'b0; rd = 1'b0; phy_addr = '0; reg_addr = '0; wr_data = '0;
      mdio_in = 1'b1;
`ifdef MDIO_PRE_SUPPRESS_EN
      pre_skip = 1'b0;
`endif
      repeat (3) tick();
      check("rst_ready", 32'(ready), 1);
      check("rst_done", 32'(done), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_rd_err", 32'(rd_err), 0);
      check("rst_mdc", 32'(mdc), 0);
      check("rst_mdio", 32'(mdio), 1);
      check("rst_oe", 32'(mdio_oe), 0);
      rst = 1'b0;
      tick();

      f = make_frame(1'b0, 5'h01, 5'h00, 16'h1140, 1'b1, 16'h0000, 1'b0);
      run_frame(f, 1'b0, f, 1'b0, -1);
      f = make_frame(1'b1, 5'h03, 5'h02, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
      run_frame(f, 1'b0, f, 1'b0, -1);
      f = make_frame(1'b1, 5'h1F, 5'h01, 16'h0000, 1'b0, 16'h0000, 1'b0);
      run_frame(f, 1'b0, f, 1'b0, -1);
      f = make_frame(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'h0, 1'b0);
      run_frame(f, 1'b0, f, 1'b0, -1);

      f = make_frame(1'b1, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 16'($urandom), 1'b0);
      g = make_frame(1'b0, f.phy ^ 5'h15, f.regad ^ 5'h0A, 16'($urandom), 1'b1, 16'h0, 1'b0);
      run_frame(f, 1'b1, g, 1'b0, -1);
      run_frame(g, 1'b0, g, 1'b1, -1);

      f = make_frame(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'h0, 1'b0);
      run_frame(f, 1'b0, f, 1'b0, 20);
      f = make_frame(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'h0, 1'b0);
      run_frame(f, 1'b0, f, 1'b0, -1);

      for (int k = 0; k < 6; k++) begin
         f = make_frame(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                        1'($urandom), 16'($urandom), 1'b0);
         run_frame(f, 1'b0, f, 1'b0, -1);
      end

`ifdef MDIO_PRE_SUPPRESS_EN
      f = make_frame(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'h0, 1'b1);
      run_frame(f, 1'b0, f, 1'b0, -1);
      f = make_frame(1'b1, 5'($urandom), 5'($urandom), 16'h0, 1'b1, 16'($urandom), 1'b1);
      run_frame(f, 1'b0, f, 1'b0, -1);
      pre_skip = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
